fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Shares the single-port framebuffer RAM between the VGA pixel-fetch path (display) and the processor/image-filter port (cpu).
- The framebuffer holds 640x480 8-bit grayscale pixels packed four per 32-bit word, big-endian: pixel 0 is in [31:24]. That is 76800 words.
- Display has priority because it is deadline-bound. The cpu is guaranteed a slot after at most MAX_DISP_RUN consecutive display grants.
- Read data is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 17, word-address width.
- FB_WORDS, 76800, number of valid words; addresses >= FB_WORDS are out of range.
- RD_LAT, 1, RAM read latency in cycles from mem_en to mem_rdata valid; range 1..4.
- MAX_DISP_RUN, 4, maximum back-to-back display grants while cpu_req is pending.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request; held until granted.
- disp_addr  in  ADDR_W  display word address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  disp_rdata valid.
- disp_rdata  out  32  display read data.
- cpu_req  in  1  cpu request; held with all fields stable until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  cpu word address.
- cpu_wdata  in  32  write data.
- cpu_be  in  4  byte enables; bit 3 selects [31:24].
- cpu_gnt  out  1  cpu request accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  32  cpu read data.
- cpu_err  out  1  one-cycle pulse when an out-of-range cpu access is accepted.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.

Behaviour:
- Reset values: every output 0; FSM in S_DISP; run counter 0; return-tag pipeline cleared.
- Reset is asynchronous: asserting rst_n mid-transfer discards all in-flight reads. No rvalid is produced after reset for commands issued before it.

Handshake:
- A transfer happens on a cycle where req and gnt are both 1. gnt is combinational from req, FSM state and run counter.
- At most one grant per cycle.
- A requester must not change its fields while req=1 and gnt=0.

FSM:
- S_DISP: disp_req wins, giving disp_gnt=1. cpu_req wins only if disp_req=0.
  - Run counter increments on each display grant while cpu_req=1.
  - Run counter clears on a cpu grant, or on any cycle with cpu_req=0.
  - When the run counter reaches MAX_DISP_RUN with cpu_req=1, go to S_CPU on the next edge. Display was granted on the cycle that completed the run.
- S_CPU: cpu_req is granted unconditionally; disp_gnt=0. Return to S_DISP the next cycle and clear the run counter.
  - If cpu_req has dropped by then, S_CPU grants nothing and returns to S_DISP.

Memory command:
- Registered: mem_* are driven on the cycle after the grant, for exactly one cycle.
- Display: mem_we=0, mem_be=4'hF.
- cpu: cpu_we, cpu_be and cpu_wdata are passed through unchanged.
- mem_wdata is 0 on reads.

Read return:
- A tag (none/disp/cpu) shifts through an RD_LAT-deep pipeline that starts at the mem_en cycle.
- rvalid for a read granted at cycle T is asserted at T+1+RD_LAT, with rdata=mem_rdata. rdata holds its last value otherwise.
- Writes produce no rvalid.
- Back-to-back grants give back-to-back rvalids, in grant order.

Out-of-range cpu access (cpu_addr >= FB_WORDS):
- Still granted.
- mem_en stays 0.
- cpu_err pulses at T+1.
- A read still returns cpu_rvalid at T+1+RD_LAT with cpu_rdata=0.

Out-of-range display address:
- Treated identically, but with no error pulse.
- disp_rdata=0, so the blank region reads black.

Decomposition:
- Package fb_pkg holds:
  - FB_H=640, FB_V=480, PIX_PER_WORD=4, FB_WORDS.
  - the address width.
  - enum fsm_t {S_DISP, S_CPU}.
  - enum tag_t {TAG_NONE, TAG_DISP, TAG_CPU}.
- One sub-module, fb_rtag_pipe: a parameterised RD_LAT-deep tag/out-of-range shift register with async clear. It produces the one-hot rvalid strobes and the rdata-zero select.

Test Plan:
- Reset, then cpu write addr 5, data 32'hA1B2C3D4, be 4'hF, no disp traffic -> cpu_gnt same cycle; next cycle mem_en=1, mem_we=1, mem_addr=5; no cpu_rvalid.
- cpu read addr 5 with RD_LAT=1 -> cpu_gnt at T; mem_en at T+1; cpu_rvalid at T+2 with cpu_rdata=32'hA1B2C3D4.
- disp_req held continuously, cpu read pending, MAX_DISP_RUN=4 -> disp_gnt at T..T+3; cpu_gnt at T+4 with disp_gnt=0; disp_gnt resumes at T+5.
- Alternating disp reads and cpu reads every cycle, RD_LAT=3 -> each rvalid arrives 4 cycles after its grant; no cross-routing; no gaps.
- cpu read addr 76800 -> cpu_gnt; mem_en stays 0; cpu_err at T+1; cpu_rvalid at T+1+RD_LAT with cpu_rdata=0.
- Display read granted, then rst_n pulsed low before rvalid is due -> all outputs 0 asynchronously; no disp_rvalid after rst_n rises; FSM in S_DISP.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer arbiter.
// Geometry: 640x480 8-bit grayscale, four pixels per 32-bit word, big-endian.
package fb_pkg;

  localparam int unsigned FB_H         = 640;
  localparam int unsigned FB_V         = 480;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned FB_WORDS     = (FB_H * FB_V) / PIX_PER_WORD;
  localparam int unsigned FB_ADDR_W    = 17;

  typedef enum logic {
    S_DISP,
    S_CPU
  } fsm_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_CPU
  } tag_t;

endpackage

// File: rtl/fb_rtag_pipe.sv
// Read-return tag pipeline: carries the requester tag and out-of-range flag
// of each granted access through RD_LAT stages aligned with the RAM read
// latency, then registers the one-hot rvalid strobes and rdata-zero select.
//   clk, rst_n    : clock, async active-low clear
//   tag_in        : tag of the access granted this cycle (TAG_NONE if none/write)
//   oor_in        : granted access is out of range (RAM not accessed)
//   disp_rvalid   : display read data valid this cycle
//   cpu_rvalid    : cpu read data valid this cycle
//   zero_sel      : returned word must read as 0
module fb_rtag_pipe
  import fb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  input  logic oor_in,
  output logic disp_rvalid,
  output logic cpu_rvalid,
  output logic zero_sel
);

  tag_t tag_q [RD_LAT];
  tag_t tag_d [RD_LAT];
  logic oor_q [RD_LAT];
  logic oor_d [RD_LAT];
  logic disp_rvalid_q, disp_rvalid_d;
  logic cpu_rvalid_q, cpu_rvalid_d;
  logic zero_sel_q, zero_sel_d;

  // Stage 0 lines up with the mem_en cycle; the last stage lines up with the
  // cycle before RAM data appears, so the output flop matches mem_rdata.
  always_comb begin
    tag_d[0] = tag_in;
    oor_d[0] = oor_in;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
      oor_d[i] = oor_q[i-1];
    end
    disp_rvalid_d = (tag_q[RD_LAT-1] == TAG_DISP);
    cpu_rvalid_d  = (tag_q[RD_LAT-1] == TAG_CPU);
    zero_sel_d    = oor_q[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_q[i] <= TAG_NONE;
        oor_q[i] <= 1'b0;
      end
      disp_rvalid_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      zero_sel_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_q[i] <= tag_d[i];
        oor_q[i] <= oor_d[i];
      end
      disp_rvalid_q <= disp_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      zero_sel_q    <= zero_sel_d;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign zero_sel    = zero_sel_q;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter between the display fetch path and the cpu port.
// Display has priority; the cpu gets a slot after MAX_DISP_RUN consecutive
// display grants while it waits. Read data is routed back by tag.
//   clk, rst_n                        : clock, async active-low reset
//   disp_req/addr -> disp_gnt         : display read request/accept
//   disp_rvalid, disp_rdata           : display read return
//   cpu_req/we/addr/wdata/be -> gnt   : cpu request/accept
//   cpu_rvalid, cpu_rdata, cpu_err    : cpu read return, out-of-range pulse
//   mem_en/we/be/addr/wdata, mem_rdata: single-port RAM interface
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned FB_WORDS     = fb_pkg::FB_WORDS,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_DISP_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [31:0]       disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned RUN_W = $clog2(MAX_DISP_RUN + 1);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);

  fsm_t              state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_err_q, cpu_err_d;
  logic [31:0]       disp_rdata_q, cpu_rdata_q;

  logic disp_oor, cpu_oor, sel_oor, issue;
  tag_t tag_in;
  logic zero_sel;

  assign disp_oor = (disp_addr > FB_LAST);
  assign cpu_oor  = (cpu_addr > FB_LAST);

  // Grant decode, run counter and next state. Grants are masked in reset so
  // every output reads 0 while rst_n is low.
  always_comb begin
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    state_d  = state_q;
    run_d    = run_q;
    case (state_q)
      S_DISP: begin
        disp_gnt = rst_n & disp_req;
        cpu_gnt  = rst_n & cpu_req & ~disp_req;
        if (!cpu_req || cpu_gnt) begin
          run_d = '0;
        end else if (disp_gnt) begin
          run_d = run_q + RUN_W'(1);
        end
        if (cpu_req && (run_d == RUN_W'(MAX_DISP_RUN))) begin
          state_d = S_CPU;
        end
      end
      S_CPU: begin
        cpu_gnt = rst_n & cpu_req;
        run_d   = '0;
        state_d = S_DISP;
      end
      default: begin
        state_d = S_DISP;
        run_d   = '0;
      end
    endcase
  end

  // Memory command for the granted requester; out-of-range accesses issue
  // nothing to the RAM but still travel down the tag pipe.
  always_comb begin
    sel_oor     = disp_gnt ? disp_oor : cpu_oor;
    issue       = (disp_gnt | cpu_gnt) & ~sel_oor;
    mem_en_d    = issue;
    mem_we_d    = issue & cpu_gnt & cpu_we;
    mem_be_d    = 4'h0;
    mem_addr_d  = '0;
    mem_wdata_d = 32'h0;
    if (issue) begin
      mem_be_d   = cpu_gnt ? cpu_be : 4'hF;
      mem_addr_d = cpu_gnt ? cpu_addr : disp_addr;
    end
    if (issue && cpu_gnt && cpu_we) begin
      mem_wdata_d = cpu_wdata;
    end
    cpu_err_d = cpu_gnt & cpu_oor;
    if (disp_gnt) begin
      tag_in = TAG_DISP;
    end else if (cpu_gnt && !cpu_we) begin
      tag_in = TAG_CPU;
    end else begin
      tag_in = TAG_NONE;
    end
  end

  // Returned data passes straight from the RAM on the valid cycle and holds
  // the last returned word otherwise.
  always_comb begin
    disp_rdata = disp_rdata_q;
    cpu_rdata  = cpu_rdata_q;
    if (disp_rvalid) begin
      disp_rdata = zero_sel ? 32'h0 : mem_rdata;
    end
    if (cpu_rvalid) begin
      cpu_rdata = zero_sel ? 32'h0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DISP;
      run_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      cpu_err_q    <= 1'b0;
      disp_rdata_q <= 32'h0;
      cpu_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_err_q    <= cpu_err_d;
      disp_rdata_q <= disp_rdata;
      cpu_rdata_q  <= cpu_rdata;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_err   = cpu_err_q;

  fb_rtag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rtag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .tag_in      (tag_in),
    .oor_in      (sel_oor),
    .disp_rvalid (disp_rvalid),
    .cpu_rvalid  (cpu_rvalid),
    .zero_sel    (zero_sel)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// sharing the requester inputs, each with its own behavioural RAM.
module tb_fb_arbiter;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_be;

  logic          disp_gnt1, disp_rvalid1, cpu_gnt1, cpu_rvalid1, cpu_err1;
  logic [31:0]   disp_rdata1, cpu_rdata1, mem_wdata1, mem_rdata1;
  logic          mem_en1, mem_we1;
  logic [3:0]    mem_be1;
  logic [AW-1:0] mem_addr1;

  logic          disp_gnt3, disp_rvalid3, cpu_gnt3, cpu_rvalid3, cpu_err3;
  logic [31:0]   disp_rdata3, cpu_rdata3, mem_wdata3, mem_rdata3;
  logic          mem_en3, mem_we3;
  logic [3:0]    mem_be3;
  logic [AW-1:0] mem_addr3;

  logic [31:0]   ram1 [64];
  logic [31:0]   ram3 [64];
  logic [31:0]   p3   [3];
  logic [31:0]   ctl1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt1),
    .disp_rvalid(disp_rvalid1), .disp_rdata(disp_rdata1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_gnt(cpu_gnt1),
    .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1), .cpu_err(cpu_err1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  fb_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt3),
    .disp_rvalid(disp_rvalid3), .disp_rdata(disp_rdata3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_gnt(cpu_gnt3),
    .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3), .cpu_err(cpu_err3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  assign ctl1 = {21'b0, mem_be1, disp_gnt1, disp_rvalid1, cpu_gnt1,
                 cpu_rvalid1, cpu_err1, mem_en1, mem_we1};

  // RAM models: latency 1 and latency 3; idle cycles return a junk word.
  always @(posedge clk) begin
    if (mem_en1 && mem_we1) begin
      for (int b = 0; b < 4; b++)
        if (mem_be1[b]) ram1[mem_addr1[5:0]][b*8 +: 8] <= mem_wdata1[b*8 +: 8];
    end
    mem_rdata1 <= (mem_en1 && !mem_we1) ? ram1[mem_addr1[5:0]] : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) begin
      for (int b = 0; b < 4; b++)
        if (mem_be3[b]) ram3[mem_addr3[5:0]][b*8 +: 8] <= mem_wdata3[b*8 +: 8];
    end
    p3[0] <= (mem_en3 && !mem_we3) ? ram3[mem_addr3[5:0]] : 32'hDEADBEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req = 1'b0;
    cpu_req  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram1[i] = 32'h1000_0000 + 32'(i);
      ram3[i] = 32'h1000_0000 + 32'(i);
    end
    rst_n = 1'b0;
    idle();
    disp_addr = '0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = 32'h0;
    cpu_be    = 4'h0;
    #2;
    chk("rst_ctl", ctl1, 32'h0);
    chk("rst_maddr", 32'(mem_addr1), 32'h0);
    chk("rst_mwdata", mem_wdata1, 32'h0);
    chk("rst_drdata", disp_rdata1, 32'h0);
    chk("rst_crdata", cpu_rdata1, 32'h0);
    #21 rst_n = 1'b1;
    repeat (2) cyc();

    // cpu write addr 5
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5;
    cpu_wdata = 32'hA1B2C3D4; cpu_be = 4'hF;
    #1;
    chk("wr_gnt", {30'b0, cpu_gnt1, disp_gnt1}, 32'h2);
    cyc(); idle(); #1;
    chk("wr_mem_en_we", {30'b0, mem_en1, mem_we1}, 32'h3);
    chk("wr_maddr", 32'(mem_addr1), 32'd5);
    chk("wr_mwdata", mem_wdata1, 32'hA1B2C3D4);
    chk("wr_mbe", 32'(mem_be1), 32'hF);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("wr_no_rvalid", {30'b0, cpu_rvalid1, cpu_rvalid3}, 32'h0);
    end

    // cpu read addr 5, RD_LAT=1
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd5;
    #1;
    chk("rd_gnt", 32'(cpu_gnt1), 32'h1);
    cyc(); idle(); #1;
    chk("rd_mem", {29'b0, mem_en1, mem_we1, cpu_rvalid1}, 32'h4);
    chk("rd_mwdata0", mem_wdata1, 32'h0);
    cyc(); #1;
    chk("rd_rvalid", 32'(cpu_rvalid1), 32'h1);
    chk("rd_rdata", cpu_rdata1, 32'hA1B2C3D4);
    cyc(); #1;
    chk("rd_rvalid_off", 32'(cpu_rvalid1), 32'h0);
    chk("rd_rdata_hold", cpu_rdata1, 32'hA1B2C3D4);
    repeat (4) cyc();

    // display run limit: disp held, cpu read pending
    disp_addr = 17'd10; cpu_we = 1'b0; cpu_addr = 17'd6;
    for (int k = 0; k < 7; k++) begin
      disp_req = (k <= 5);
      cpu_req  = (k <= 4);
      #1;
      chk($sformatf("run_gnt_%0d", k), {30'b0, disp_gnt1, cpu_gnt1},
          (k == 4) ? 32'h1 : (k <= 5) ? 32'h2 : 32'h0);
      if (k == 6) begin
        chk("run_cpu_rvalid", 32'(cpu_rvalid1), 32'h1);
        chk("run_cpu_rdata", cpu_rdata1, 32'h1000_0006);
      end
      cyc();
    end
    idle();
    repeat (6) cyc();

    // alternating disp/cpu reads on the RD_LAT=3 instance
    for (int j = 0; j < 11; j++) begin
      if (j < 6) begin
        disp_req  = (j % 2 == 0);
        cpu_req   = (j % 2 == 1);
        disp_addr = AW'(20 + j);
        cpu_addr  = AW'(20 + j);
      end else begin
        idle();
      end
      #1;
      chk($sformatf("alt_gnt_%0d", j), {30'b0, disp_gnt3, cpu_gnt3},
          (j >= 6) ? 32'h0 : (j % 2 == 0) ? 32'h2 : 32'h1);
      chk($sformatf("alt_rv_%0d", j), {30'b0, disp_rvalid3, cpu_rvalid3},
          (j < 4 || j > 9) ? 32'h0 : ((j - 4) % 2 == 0) ? 32'h2 : 32'h1);
      if (j >= 4 && j <= 9) begin
        if ((j - 4) % 2 == 0)
          chk($sformatf("alt_drd_%0d", j), disp_rdata3, 32'h1000_0000 + 32'(16 + j));
        else
          chk($sformatf("alt_crd_%0d", j), cpu_rdata3, 32'h1000_0000 + 32'(16 + j));
      end
      cyc();
    end
    repeat (4) cyc();

    // cpu read out of range
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd76800;
    #1;
    chk("oor_gnt", 32'(cpu_gnt1), 32'h1);
    cyc(); idle(); #1;
    chk("oor_mem_en", {30'b0, mem_en1, mem_en3}, 32'h0);
    chk("oor_err", {30'b0, cpu_err1, cpu_err3}, 32'h3);
    cyc(); #1;
    chk("oor_err_off", 32'(cpu_err1), 32'h0);
    chk("oor_rvalid1", 32'(cpu_rvalid1), 32'h1);
    chk("oor_rdata1", cpu_rdata1, 32'h0);
    cyc(); cyc(); #1;
    chk("oor_rvalid3", 32'(cpu_rvalid3), 32'h1);
    chk("oor_rdata3", cpu_rdata3, 32'h0);
    repeat (3) cyc();

    // last valid word is still in range
    cpu_req = 1'b1; cpu_addr = 17'd76799;
    cyc(); idle(); #1;
    chk("last_mem_en", 32'(mem_en1), 32'h1);
    chk("last_maddr", 32'(mem_addr1), 32'd76799);
    chk("last_err", 32'(cpu_err1), 32'h0);
    cyc(); #1;
    chk("last_rdata", cpu_rdata1, 32'h1000_003F);
    repeat (3) cyc();

    // display read out of range: black, no error
    disp_req = 1'b1; disp_addr = 17'h1FFFF;
    #1;
    chk("door_gnt", 32'(disp_gnt1), 32'h1);
    cyc(); idle(); #1;
    chk("door_mem_err", {30'b0, mem_en1, cpu_err1}, 32'h0);
    cyc(); #1;
    chk("door_rvalid", 32'(disp_rvalid1), 32'h1);
    chk("door_rdata", disp_rdata1, 32'h0);
    repeat (4) cyc();

    // reset while a display read is in flight
    disp_req = 1'b1; disp_addr = 17'd7;
    #1;
    chk("rr_gnt", 32'(disp_gnt1), 32'h1);
    cyc(); #1;
    chk("rr_mem_en", 32'(mem_en1), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_ctl", ctl1, 32'h0);
    chk("rr_maddr", 32'(mem_addr1), 32'h0);
    chk("rr_drdata", disp_rdata1, 32'h0);
    cyc(); #2;
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_no_rvalid", {30'b0, disp_rvalid1, disp_rvalid3}, 32'h0);
      cyc();
    end
    disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    chk("rr_sdisp", {30'b0, disp_gnt1, cpu_gnt1}, 32'h2);
    cyc(); idle();
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
